// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake plus the held
// instruction / retire handshake towards the control unit.
interface instr_fetch_unit_if;
  // instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // core / decoder side
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7_5;
  logic        instr_ready;
  logic        pc_src;
  logic [31:0] pc_target;

  // the fetch unit drives requests and the held instruction
  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc, pc_plus4, opcode, func3, func7_5,
    input  instr_ready, pc_src, pc_target
  );

  // memory model and core see the mirror image
  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc, pc_plus4, opcode, func3, func7_5,
    output instr_ready, pc_src, pc_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time, holds it
// for the decoder until retire, then picks the next PC and counts retires.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_unit_if.master         bus,
  output logic                       misalign_err,
  output logic [31:0]                instret
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] next_pc;

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    instret_d     = instret_q;
    next_pc       = bus.pc_src ? bus.pc_target : (instr_pc_q + 32'd4);

    case (state_q)
      S_REQ: begin
        // address is fetch_pc_q and stays put until memory accepts
        if (bus.imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d       = bus.imem_rdata;
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          instret_d     = instret_q + 32'd1;
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
          if (bus.pc_src && (bus.pc_target[1:0] != 2'b00)) begin
            // a misaligned taken target stops fetching until reset
            misalign_d = 1'b1;
            state_d    = S_ERR;
          end else begin
            fetch_pc_d = next_pc;
            state_d    = S_REQ;
          end
        end
      end
      default: begin
        // S_ERR: terminal, nothing moves
        state_d = S_ERR;
      end
    endcase
  end

  // State register; reset overrides any simultaneous retire or response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      instret_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      instret_q     <= instret_d;
    end
  end

  // Request is suppressed while reset is held so the first request lands in
  // the first cycle after reset drops.
  assign bus.imem_req    = (state_q == S_REQ) && !rst;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc_plus4    = instr_pc_q + 32'd4;
  assign bus.opcode      = instr_q[6:0];
  assign bus.func3       = instr_q[14:12];
  assign bus.func7_5     = instr_q[30];
  assign misalign_err    = misalign_q;
  assign instret         = instret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue scoreboard: stimulus
// tasks push the expected fetch addresses and instructions, a negedge monitor
// pops and compares whenever the DUT accepts a request or presents a word.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        misalign_err;
  logic [31:0] instret;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.master),
    .misalign_err (misalign_err),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_exp_q[$];
  logic [31:0] pc_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: request accepts and newly presented instructions.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.imem_req && bus.imem_ready) begin
      if (addr_q.size() == 0) check("unexpected_req", bus.imem_addr, 32'hxxxx_xxxx);
      else begin
        logic [31:0] ea;
        ea = addr_q.pop_front();
        check("fetch_addr", bus.imem_addr, ea);
        $display("req  addr=%h", bus.imem_addr);
      end
    end
    if (bus.instr_valid && !prev_valid) begin
      if (instr_exp_q.size() == 0) check("unexpected_valid", bus.instr, 32'hxxxx_xxxx);
      else begin
        logic [31:0] ei, ep;
        ei = instr_exp_q.pop_front();
        ep = pc_exp_q.pop_front();
        check("instr", bus.instr, ei);
        check("instr_pc", bus.instr_pc, ep);
        check("pc_plus4", bus.pc_plus4, ep + 32'd4);
        $display("rsp  pc=%h instr=%h", bus.instr_pc, bus.instr);
      end
    end
    prev_valid <= bus.instr_valid;
  end

  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.imem_req && n < 20);
    check("req_seen", {31'd0, bus.imem_req}, 32'd1);
  endtask

  // Memory side: optional stall, accept, one-cycle rvalid with data.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int stall);
    addr_q.push_back(addr);
    instr_exp_q.push_back(data);
    pc_exp_q.push_back(addr);
    wait_req();
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      bus.imem_ready = 1'b0;
      // junk on retire inputs outside HOLD must be ignored
      bus.instr_ready = 1'b1; bus.pc_src = 1'b1; bus.pc_target = 32'h42;
      @(negedge clk);
      check("stall_addr", bus.imem_addr, addr);
      check("stall_req", {31'd0, bus.imem_req}, 32'd1);
    end
    @(posedge clk); #1;
    bus.instr_ready = 1'b0; bus.pc_src = 1'b0; bus.pc_target = 32'd0;
    bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = data;
    @(negedge clk);
    check("wait_no_req", {31'd0, bus.imem_req}, 32'd0);
    check("wait_no_valid", {31'd0, bus.instr_valid}, 32'd0);
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    @(negedge clk);
    check("valid_n2", {31'd0, bus.instr_valid}, 32'd1);
  endtask

  // Core side: hold for a while, then retire with the given redirect.
  task automatic retire(input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] cnt,
                        input int hold, input bit src, input logic [31:0] tgt);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_instr", bus.instr, ei);
      check("hold_pc", bus.instr_pc, ep);
      check("hold_instret", instret, cnt);
      check("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
    end
    @(posedge clk); #1;
    bus.instr_ready = 1'b1; bus.pc_src = src; bus.pc_target = tgt;
    @(negedge clk);
    check("opcode", {25'd0, bus.opcode}, {25'd0, ei[6:0]});
    check("func3", {29'd0, bus.func3}, {29'd0, ei[14:12]});
    check("func7_5", {31'd0, bus.func7_5}, {31'd0, ei[30]});
    check("pc_plus4_hold", bus.pc_plus4, ep + 32'd4);
    @(posedge clk); #1;
    bus.instr_ready = 1'b0; bus.pc_src = 1'b0; bus.pc_target = 32'd0;
    @(negedge clk);
    check("instret_after", instret, cnt + 32'd1);
    check("valid_cleared", {31'd0, bus.instr_valid}, 32'd0);
    check("instr_nop", bus.instr, NOP);
    if (src && tgt[1:0] != 2'b00) begin
      check("misalign_set", {31'd0, misalign_err}, 32'd1);
      check("err_no_req", {31'd0, bus.imem_req}, 32'd0);
    end else begin
      check("next_req", {31'd0, bus.imem_req}, 32'd1);
      check("next_addr", bus.imem_addr, src ? tgt : ep + 32'd4);
      check("misalign_clr", {31'd0, misalign_err}, 32'd0);
    end
    $display("ret  pc=%h src=%0d tgt=%h instret=%h", ep, src, tgt, instret);
  endtask

  initial begin
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    bus.instr_ready = 1'b0; bus.pc_src = 1'b0; bus.pc_target = 32'd0;

    // reset values
    @(negedge clk);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, NOP);
    check("rst_pc", bus.instr_pc, 32'd0);
    check("rst_pc4", bus.pc_plus4, 32'd4);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("first_req", {31'd0, bus.imem_req}, 32'd1);

    // sequential stream
    fetch(32'h0, 32'h0050_0093, 0);
    retire(32'h0050_0093, 32'h0, 32'd0, 0, 1'b0, 32'd0);
    fetch(32'h4, 32'h0010_0113, 0);
    retire(32'h0010_0113, 32'h4, 32'd1, 0, 1'b0, 32'd0);
    check("instret_two", instret, 32'd2);

    // backpressure on both handshakes
    fetch(32'h8, 32'h4020_8133, 3);
    retire(32'h4020_8133, 32'h8, 32'd2, 4, 1'b0, 32'd0);

    // taken branch from 0x10 to 0x40
    fetch(32'hC, NOP, 0);
    retire(NOP, 32'hC, 32'd3, 0, 1'b0, 32'd0);
    fetch(32'h10, 32'h0300_006F, 0);
    retire(32'h0300_006F, 32'h10, 32'd4, 1, 1'b1, 32'h40);

    // wrap of PC and instret
    fetch(32'h40, 32'h0000_006F, 0);
    retire(32'h0000_006F, 32'h40, 32'd5, 0, 1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, NOP, 0);
    force dut.instret_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.instret_q;
    retire(NOP, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 1'b0, 32'd0);
    check("instret_wrap", instret, 32'd0);

    // misaligned target, then sticky error
    fetch(32'h0, NOP, 0);
    retire(NOP, 32'h0, 32'd0, 0, 1'b1, 32'h42);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.imem_rvalid = (i == 1); bus.imem_rdata = 32'hDEAD_BEEF; bus.imem_ready = 1'b1;
      @(negedge clk);
      check("err_sticky", {31'd0, misalign_err}, 32'd1);
      check("err_req", {31'd0, bus.imem_req}, 32'd0);
      check("err_valid", {31'd0, bus.instr_valid}, 32'd0);
    end
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0; bus.imem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("err_rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("err_rst_instret", instret, 32'd0);
    check("err_rst_req", {31'd0, bus.imem_req}, 32'd1);

    // stray rvalid in S_REQ
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    @(negedge clk);
    check("stray_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("stray_instr", bus.instr, NOP);
    check("stray_req", {31'd0, bus.imem_req}, 32'd1);

    // reset while in S_WAIT abandons the fetch
    addr_q.push_back(32'h0);
    @(posedge clk); #1;
    bus.imem_ready = 1'b1;
    @(posedge clk); #1;
    bus.imem_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_addr", bus.imem_addr, 32'h0);
    check("abort_req", {31'd0, bus.imem_req}, 32'd1);
    check("abort_instret", instret, 32'd0);
    fetch(32'h0, 32'h0050_0093, 0);
    retire(32'h0050_0093, 32'h0, 32'd0, 0, 1'b0, 32'd0);

    check("addr_q_empty", addr_q.size(), 32'd0);
    check("instr_q_empty", instr_exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the single-cycle RV32 core, directly upstream of the control unit. It owns the PC register and fetches one instruction at a time from instruction memory over a req/ready + rvalid handshake. It holds the fetched word stable, presenting `opcode`/`func3`/`func7_5` to the decoder, until the core retires it. On retire it consumes `pc_src`/`pc_target` to choose the next PC, and it counts retired instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; must be word-aligned.
- `NOP_INSTR`, default 32'h0000_0013: `instr` value whenever no valid instruction is held (addi x0,x0,0).

Ports (`clk` and `rst` first; one clock, `rst` synchronous and active-high):
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch byte address (= `fetch_pc`).
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  fetched instruction word.
- `instr_valid`  out  1  `instr` holds a fetched, unretired instruction.
- `instr`  out  32  held instruction; `NOP_INSTR` when `instr_valid`=0.
- `instr_pc`  out  32  PC of `instr`.
- `pc_plus4`  out  32  `instr_pc` + 4, used for the jal link value.
- `opcode`  out  7  `instr[6:0]`.
- `func3`  out  3  `instr[14:12]`.
- `func7_5`  out  1  `instr[30]`.
- `instr_ready`  in  1  core retires `instr` this cycle.
- `pc_src`  in  1  control unit PCSrc; take `pc_target` on retire.
- `pc_target`  in  32  branch/jump target.
- `misalign_err`  out  1  sticky: a taken target was not word-aligned.
- `instret`  out  32  retired-instruction count.

## Operation
- States: S_REQ, S_WAIT, S_HOLD, S_ERR.
- S_REQ:
  - `imem_req`=1, `imem_addr`=`fetch_pc`.
  - `imem_ready`=1 → S_WAIT.
  - Address stays stable while `imem_ready`=0.
- S_WAIT:
  - `imem_req`=0.
  - `imem_rvalid`=1 → capture `imem_rdata` into `instr` and `fetch_pc` into `instr_pc`, set `instr_valid`=1, go to S_HOLD.
- S_HOLD:
  - `instr_valid`=1; all outputs stable.
  - `instr_ready`=1 (retire):
    - `instret` += 1 (wraps 32'hFFFF_FFFF → 0).
    - `instr_valid` ← 0, `instr` ← `NOP_INSTR`.
    - Next PC = `pc_src` ? `pc_target` : `instr_pc`+4.
    - If `pc_src`=1 and `pc_target[1:0]`≠0: `misalign_err` ← 1, → S_ERR. Otherwise `fetch_pc` ← next PC, → S_REQ.
- S_ERR:
  - Terminal until `rst`.
  - `imem_req`=0, `instr_valid`=0, `misalign_err`=1.
- Inputs outside their state are ignored:
  - `imem_rvalid` outside S_WAIT is dropped.
  - `instr_ready`, `pc_src`, `pc_target` are sampled only in S_HOLD.
- PC arithmetic is 32-bit modulo; `instr_pc`=32'hFFFF_FFFC sequential next PC is 0.
- At most one outstanding request. No new request issues before the previous instruction retires, so no flush or kill logic exists.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr`=`NOP_INSTR`, `instr_pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
  - `misalign_err`=0, `instret`=0.
  - State=S_REQ, `fetch_pc`=`RESET_PC`.
- First `imem_req`=1 is in the first cycle with `rst`=0.
- Handshake in cycle N with `imem_ready`=1 and `imem_rvalid`=1 in N+1 → `instr_valid`=1 in N+2.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with `instr_ready`=1).
- Redirect timing: retire in cycle M with `pc_src`=1 → `imem_addr`=`pc_target` with `imem_req`=1 in M+1.
- `rst` mid-operation (any state) returns to reset values next edge and abandons any in-flight fetch. Instruction memory shares `rst` and drops outstanding requests.
- `rst` wins over every simultaneous event, including a retire in the same cycle.
- `instret` and `misalign_err` update on the same edge as the retire that causes them.

## Test plan
- Reset, sequential stream:
  - Stimulus: `rst` 2 cycles; memory returns 32'h00500093, 32'h00100113 with ready=1 and 1-cycle rvalid; `instr_ready`=1.
  - Response: fetch addresses 0x0 then 0x4; `instr_valid` 2 cycles after each accept; `instret`=2; `opcode`=0x13, `func3`=0.
- Backpressure:
  - Stimulus: `imem_ready` low 3 cycles, `instr_ready` low 4 cycles in S_HOLD.
  - Response: `imem_addr` stable through the stall; `instr`/`instr_pc` stable through the hold; `instret` unchanged until retire.
- Taken branch:
  - Stimulus: retire at `instr_pc`=0x10 with `pc_src`=1, `pc_target`=0x40.
  - Response: next `imem_addr`=0x40 one cycle after retire; `pc_plus4`=0x14 during hold.
- Misaligned target:
  - Stimulus: retire with `pc_src`=1, `pc_target`=0x42.
  - Response: `misalign_err`=1; `imem_req` stays 0; `instr_valid` stays 0 until `rst`, which clears both.
- Stray responses and reset mid-fetch:
  - Stimulus: `imem_rvalid` pulse in S_REQ; `rst` asserted in S_WAIT.
  - Response: the stray pulse is ignored; after `rst` the next fetch address is `RESET_PC` and `instret`=0.
- Wrap:
  - Stimulus: retire at `instr_pc`=0xFFFFFFFC with `pc_src`=0; `instret` preloaded to 0xFFFFFFFF.
  - Response: next fetch 0x0; `instret`=0.
